// File: rtl/tank_ctrl_p.sv
`default_nettype none
// ============================================================================
// Module   : tank_ctrl_p
// Desc     : Per-tank controller: movement, facing, gated fire with cooldown,
//            lives and kill/respawn FSM. Optional macro: TANK_SHIELD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tank_ctrl_p #(
    parameter int POS_W          = 10,
    parameter int SCREEN_W       = 640,
    parameter int SCREEN_H       = 480,
    parameter int TANK_SIZE      = 32,
    parameter int START_X        = 304,
    parameter int START_Y        = 448,
    parameter int MOVE_DIV       = 4,
    parameter int STEP           = 1,
    parameter int COOLDOWN       = 8,
    parameter int LIVES          = 3,
    parameter int RESPAWN_CYCLES = 16,
    parameter int SHIELD_CYCLES  = 32,
    parameter int TANK_ID        = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             killed,
    input  logic             up,
    input  logic             down,
    input  logic             left,
    input  logic             right,
    input  logic             fire,
    input  logic             bullet_ready,
    output logic             bullet_fire,
    output logic [1:0]       bullet_direction,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y,
    output logic [2:0]       tank_addr,
    output logic [31:0]      tank_state,
    output logic             alive,
    output logic [2:0]       lives_left
);

    localparam logic [1:0] c_ST_ALIVE = 2'd0;
    localparam logic [1:0] c_ST_DYING = 2'd1;
    localparam logic [1:0] c_ST_DEAD  = 2'd2;

    localparam logic [1:0] c_DIR_UP    = 2'd0;
    localparam logic [1:0] c_DIR_DOWN  = 2'd1;
    localparam logic [1:0] c_DIR_LEFT  = 2'd2;
    localparam logic [1:0] c_DIR_RIGHT = 2'd3;

    localparam int c_CW = $clog2(COOLDOWN + 1);
    localparam int c_TW = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;
    localparam int c_MW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int c_PW = POS_W + 1;

    localparam logic [c_MW-1:0] c_MOVE_LAST = c_MW'(MOVE_DIV - 1);
    localparam logic [c_PW-1:0] c_STEP_E    = c_PW'(STEP);
    localparam logic [c_PW-1:0] c_X_MAX     = c_PW'(SCREEN_W - TANK_SIZE);
    localparam logic [c_PW-1:0] c_Y_MAX     = c_PW'(SCREEN_H - TANK_SIZE);

`ifdef TANK_SHIELD_EN
    localparam logic c_SHIELD_RST = (SHIELD_CYCLES != 0);
`else
    localparam logic c_SHIELD_RST = 1'b0;
`endif

    localparam logic [31:0] c_RESET_WORD = {3'(TANK_ID), c_SHIELD_RST, 1'b0, 3'(LIVES),
                                            c_ST_ALIVE, c_DIR_UP, 10'(START_X), 10'(START_Y)};

    logic [1:0]       r_state;
    logic [2:0]       r_lives;
    logic [POS_W-1:0] r_pos_x;
    logic [POS_W-1:0] r_pos_y;
    logic [1:0]       r_dir;
    logic [c_MW-1:0]  r_move_cnt;
    logic [c_CW-1:0]  r_cooldown;
    logic [c_TW-1:0]  r_timer;
    logic             r_fire_d;
    logic             r_bullet_fire;
    logic [1:0]       r_bullet_dir;
    logic [31:0]      r_tank_state;

    logic             w_any_req;
    logic [1:0]       w_req_dir;
    logic [c_PW-1:0]  w_x_ext;
    logic [c_PW-1:0]  w_y_ext;
    logic [c_PW-1:0]  w_x_inc;
    logic [c_PW-1:0]  w_y_inc;
    logic [POS_W-1:0] w_next_x;
    logic [POS_W-1:0] w_next_y;
    logic             w_shield_on;
    logic             w_kill;
    logic             w_shot;
    logic             w_respawn;
    logic [31:0]      w_status;

    assign w_any_req = up | down | left | right;
    assign w_x_ext   = {1'b0, r_pos_x};
    assign w_y_ext   = {1'b0, r_pos_y};
    assign w_x_inc   = w_x_ext + c_STEP_E;
    assign w_y_inc   = w_y_ext + c_STEP_E;

    always_comb begin
        if (up)        w_req_dir = c_DIR_UP;
        else if (down) w_req_dir = c_DIR_DOWN;
        else if (left) w_req_dir = c_DIR_LEFT;
        else           w_req_dir = c_DIR_RIGHT;
    end

    // Steps saturate at the playfield edges instead of wrapping.
    always_comb begin
        w_next_x = r_pos_x;
        w_next_y = r_pos_y;
        case (w_req_dir)
            c_DIR_UP:   w_next_y = (w_y_ext < c_STEP_E) ? '0 : POS_W'(w_y_ext - c_STEP_E);
            c_DIR_DOWN: w_next_y = (w_y_inc > c_Y_MAX) ? POS_W'(c_Y_MAX) : POS_W'(w_y_inc);
            c_DIR_LEFT: w_next_x = (w_x_ext < c_STEP_E) ? '0 : POS_W'(w_x_ext - c_STEP_E);
            default:    w_next_x = (w_x_inc > c_X_MAX) ? POS_W'(c_X_MAX) : POS_W'(w_x_inc);
        endcase
    end

    assign w_respawn = (r_state == c_ST_DYING) && (r_timer == '0);
    assign w_kill    = killed & ~w_shield_on;
    assign w_shot    = fire & ~r_fire_d & (r_cooldown == '0) & bullet_ready;

`ifdef TANK_SHIELD_EN
    localparam int c_SW = $clog2(SHIELD_CYCLES + 1);
    logic [c_SW-1:0] r_shield;

    always_ff @(posedge clk) begin
        if (reset || w_respawn) begin
            r_shield <= c_SW'(SHIELD_CYCLES);
        end else if (r_shield != '0) begin
            r_shield <= r_shield - c_SW'(1);
        end
    end

    assign w_shield_on = (r_shield != '0);
`else
    assign w_shield_on = 1'b0;
`endif

    assign w_status = {3'(TANK_ID), w_shield_on, (r_cooldown != '0), r_lives,
                       r_state, r_dir, 10'(r_pos_x), 10'(r_pos_y)};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_ST_ALIVE;
            r_lives       <= 3'(LIVES);
            r_pos_x       <= POS_W'(START_X);
            r_pos_y       <= POS_W'(START_Y);
            r_dir         <= c_DIR_UP;
            r_move_cnt    <= '0;
            r_cooldown    <= '0;
            r_timer       <= '0;
            r_fire_d      <= 1'b0;
            r_bullet_fire <= 1'b0;
            r_bullet_dir  <= c_DIR_UP;
            r_tank_state  <= c_RESET_WORD;
        end else begin
            r_fire_d      <= fire;
            r_bullet_fire <= 1'b0;
            r_tank_state  <= w_status;
            if (r_cooldown != '0) begin
                r_cooldown <= r_cooldown - c_CW'(1);
            end
            case (r_state)
                c_ST_ALIVE: begin
                    if (w_any_req) begin
                        r_dir <= w_req_dir;
                        if (r_move_cnt == c_MOVE_LAST) begin
                            r_move_cnt <= '0;
                            r_pos_x    <= w_next_x;
                            r_pos_y    <= w_next_y;
                        end else begin
                            r_move_cnt <= r_move_cnt + c_MW'(1);
                        end
                    end else begin
                        r_move_cnt <= '0;
                    end
                    // A kill suppresses any shot requested in the same cycle.
                    if (w_kill) begin
                        r_lives <= r_lives - 3'd1;
                        if (r_lives == 3'd1) begin
                            r_state <= c_ST_DEAD;
                        end else begin
                            r_state <= c_ST_DYING;
                            r_timer <= c_TW'(RESPAWN_CYCLES - 1);
                        end
                    end else if (w_shot) begin
                        r_bullet_fire <= 1'b1;
                        r_bullet_dir  <= r_dir;
                        r_cooldown    <= c_CW'(COOLDOWN);
                    end
                end
                c_ST_DYING: begin
                    r_move_cnt <= '0;
                    if (w_respawn) begin
                        r_state    <= c_ST_ALIVE;
                        r_pos_x    <= POS_W'(START_X);
                        r_pos_y    <= POS_W'(START_Y);
                        r_dir      <= c_DIR_UP;
                        r_cooldown <= '0;
                    end else begin
                        r_timer <= r_timer - c_TW'(1);
                    end
                end
                default: begin
                    r_move_cnt <= '0;
                end
            endcase
        end
    end

    assign bullet_fire      = r_bullet_fire;
    assign bullet_direction = r_bullet_dir;
    assign pos_x            = r_pos_x;
    assign pos_y            = r_pos_y;
    assign tank_addr        = 3'(TANK_ID);
    assign tank_state       = r_tank_state;
    assign alive            = (r_state == c_ST_ALIVE);
    assign lives_left       = r_lives;

endmodule
`default_nettype wire
